sccb_reg_sequencer: RTL

Parametrised register-programming sequencer for SCCB/I2C camera sensors; successor to the OV7670-only configuration FSM. It walks a synchronous ROM of {address, data} words with end and delay markers, feeds the SCCB master one write at a time, and then accepts runtime register writes through a valid/ready port. It sits between the boot ROM, the keypad/command logic and the SCCB master, all in the 25 MHz domain.

---
 rtl/sccb_reg_sequencer_if.sv | 37 +++
 rtl/sccb_reg_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sccb_reg_sequencer_if
// Brief    : Command/response bus between the register sequencer and the
//            SCCB master (one-cycle start pulse, ready/read-data return).
// Revision : 1.0 - initial release
// ============================================================================
interface sccb_reg_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              sccb_start;
    logic              sccb_we;
    logic [ADDR_W-1:0] sccb_address;
    logic [DATA_W-1:0] sccb_data;
    logic              sccb_ready;
    logic [DATA_W-1:0] sccb_rdata;

    modport master (
        output sccb_start,
        output sccb_we,
        output sccb_address,
        output sccb_data,
        input  sccb_ready,
        input  sccb_rdata
    );

    modport slave (
        input  sccb_start,
        input  sccb_we,
        input  sccb_address,
        input  sccb_data,
        output sccb_ready,
        output sccb_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sccb_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sccb_reg_sequencer
// Brief    : Walks a {addr,data} boot ROM (END / DELAY markers) into the SCCB
//            master, then serves runtime writes. Optional read-back verify
//            with retries is enabled by defining SCCB_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_reg_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int ROM_AW       = 8,
    parameter int DELAY_CYCLES = 250000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                     clk_25M,
    input  logic                     rst_n_25M,
    input  logic                     start,
    output logic [ROM_AW-1:0]        rom_address,
    input  logic [ADDR_W+DATA_W-1:0] rom_data,
    input  logic                     usr_valid,
    output logic                     usr_ready,
    input  logic [ADDR_W-1:0]        usr_addr,
    input  logic [DATA_W-1:0]        usr_data,
    sccb_reg_sequencer_if.master     sccb,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [7:0]               err_count
);
    localparam int c_WORD_W = ADDR_W + DATA_W;
    localparam int c_DLY_W  = $clog2(DELAY_CYCLES + 1);
    localparam logic [c_WORD_W-1:0] c_END_WORD   = '1;
    localparam logic [c_WORD_W-1:0] c_DELAY_WORD = {{(c_WORD_W-4){1'b1}}, 4'b0000};

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_ISSUE     = 4'd3,
        S_WAIT_LOW  = 4'd4,
        S_WAIT_HIGH = 4'd5,
        S_DELAY     = 4'd6,
        S_VERIFY    = 4'd7,
        S_USER      = 4'd8
    } state_t;

    state_t              r_state;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic                r_sccb_start;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_done;
    logic [c_DLY_W-1:0]  r_dly_cnt;
    logic                r_is_user;

`ifdef SCCB_VERIFY_EN
    localparam int c_RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic                r_we;
    logic                r_reading;
    logic                r_err;
    logic [c_RTY_W-1:0]  r_retry;
    logic [7:0]          r_err_cnt;
    logic [DATA_W-1:0]   r_rdata;
`endif

    always_ff @(posedge clk_25M) begin
        if (!rst_n_25M) begin
            r_state      <= S_IDLE;
            r_rom_addr   <= '0;
            r_sccb_start <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_dly_cnt    <= '0;
            r_is_user    <= 1'b0;
`ifdef SCCB_VERIFY_EN
            r_we         <= 1'b0;
            r_reading    <= 1'b0;
            r_err        <= 1'b0;
            r_retry      <= '0;
            r_err_cnt    <= '0;
            r_rdata      <= '0;
`endif
        end else begin
            r_sccb_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rom_addr <= '0;
                        r_done     <= 1'b0;
                        r_is_user  <= 1'b0;
`ifdef SCCB_VERIFY_EN
                        r_err      <= 1'b0;
                        r_err_cnt  <= '0;
`endif
                        r_state    <= S_FETCH;
                    end else if (r_done && usr_valid) begin
                        r_addr    <= usr_addr;
                        r_data    <= usr_data;
                        r_is_user <= 1'b1;
`ifdef SCCB_VERIFY_EN
                        r_reading <= 1'b0;
                        r_retry   <= '0;
`endif
                        r_state   <= S_USER;
                    end
                end

                S_FETCH: r_state <= S_DECODE;

                S_DECODE: begin
                    if (rom_data == c_END_WORD) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (rom_data == c_DELAY_WORD) begin
                        // Counting down from DELAY_CYCLES, including the zero
                        // cycle, holds DELAY for DELAY_CYCLES+1 cycles.
                        r_dly_cnt  <= c_DLY_W'(DELAY_CYCLES);
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_state    <= S_DELAY;
                    end else begin
                        r_addr  <= rom_data[c_WORD_W-1:DATA_W];
                        r_data  <= rom_data[DATA_W-1:0];
`ifdef SCCB_VERIFY_EN
                        r_reading <= 1'b0;
                        r_retry   <= '0;
`endif
                        r_state <= S_ISSUE;
                    end
                end

                S_DELAY: begin
                    if (r_dly_cnt == '0) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - 1'b1;
                    end
                end

                S_USER: r_state <= S_ISSUE;

                S_ISSUE: begin
                    if (sccb.sccb_ready) begin
                        r_sccb_start <= 1'b1;
`ifdef SCCB_VERIFY_EN
                        r_we         <= ~r_reading;
`endif
                        r_state      <= S_WAIT_LOW;
                    end
                end

                S_WAIT_LOW: begin
                    if (!sccb.sccb_ready) begin
                        r_state <= S_WAIT_HIGH;
                    end
                end

                S_WAIT_HIGH: begin
                    if (sccb.sccb_ready) begin
`ifdef SCCB_VERIFY_EN
                        if (r_reading) begin
                            r_rdata <= sccb.sccb_rdata;
                            r_state <= S_VERIFY;
                        end else begin
                            r_reading <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
`else
                        if (r_is_user) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rom_addr <= r_rom_addr + 1'b1;
                            r_state    <= S_FETCH;
                        end
`endif
                    end
                end

`ifdef SCCB_VERIFY_EN
                S_VERIFY: begin
                    if ((r_rdata != r_data) && (r_retry != c_RTY_W'(MAX_RETRY))) begin
                        r_retry   <= r_retry + 1'b1;
                        r_reading <= 1'b0;
                        r_state   <= S_ISSUE;
                    end else begin
                        // Retries exhausted: flag it and move on to the next word.
                        if (r_rdata != r_data) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                        if (r_is_user) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rom_addr <= r_rom_addr + 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
`endif

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_address       = r_rom_addr;
    assign sccb.sccb_start   = r_sccb_start;
    assign sccb.sccb_address = r_addr;
    assign sccb.sccb_data    = r_data;
    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
    assign usr_ready         = (r_state == S_IDLE) && r_done && !start;

`ifdef SCCB_VERIFY_EN
    assign sccb.sccb_we = r_we;
    assign err          = r_err;
    assign err_count    = r_err_cnt;
`else
    logic w_unused;

    assign sccb.sccb_we = 1'b1;
    assign err          = 1'b0;
    assign err_count    = 8'h00;
    assign w_unused     = &{1'b0, sccb.sccb_rdata, (MAX_RETRY > 0)};
`endif
endmodule
`default_nettype wire
